seg7_scan_ctrl: RTL and testbench

//  Parametrised multiplexed seven-segment display scanner; next generation of our fixed 8-digit anode selector.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_hex_decode.sv | 14 +
 rtl/seg7_scan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types, segment table and polarity helpers for the seven-segment
// scan controller and its decoder.
package seg7_pkg;

    typedef enum logic [1:0] {
        S_BLANK = 2'd0,
        S_ON    = 2'd1,
        S_OFF   = 2'd2
    } scan_st_t;

    // Active-high segments, bit0=a .. bit6=g, for hex 0..F (0-9, A, b, C, d, E, F).
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] SEG_OFF(input logic act_low);
        return act_low ? 7'h7F : 7'h00;
    endfunction

    // Wide enough for the largest digit count; callers truncate to NDIG.
    function automatic logic [15:0] AN_OFF(input logic act_low);
        return act_low ? 16'hFFFF : 16'h0000;
    endfunction

    function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input logic act_low);
        return act_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-seven-segment decoder, active-high output.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Table lookup of the segment pattern for one hex digit.
    always_comb begin
        seg_o = SEG_TABLE[hex_i];
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner: round-robin digit slots with dead-time
// blanking, PWM brightness and frame-synchronous double-buffered loading.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NDIG        = 8,
    parameter int DIV         = 50000,
    parameter int BLANK       = 64,
    parameter bit AN_ACT_LOW  = 1'b1,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*NDIG-1:0]   digits_i,
    input  logic [NDIG-1:0]     dp_i,
    input  logic [NDIG-1:0]     enable_i,
    input  logic [3:0]          bright_i,
    input  logic                load_i,
    output logic [NDIG-1:0]     anode_o,
    output logic [6:0]          seg_o,
    output logic                dp_o,
    output logic                frame_o
);

    localparam int                CNT_W      = $clog2(DIV);
    localparam int                IDX_W      = $clog2(NDIG);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NDIG - 1);
    localparam logic [31:0]       SLOT_SPAN  = 32'(DIV - BLANK);
    localparam logic [NDIG-1:0]   AN_IDLE    = NDIG'(AN_OFF(AN_ACT_LOW));
    localparam logic [6:0]        SEG_IDLE   = SEG_OFF(SEG_ACT_LOW);
    localparam logic              DP_IDLE    = SEG_ACT_LOW;

    logic [CNT_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   idx_r;
    scan_st_t           state_r;
    scan_st_t           state_nx_s;
    logic [3:0]         br_r;
    logic [31:0]        on_len_s;
    logic               on_done_s;
    logic               tick_s;
    logic               frame_edge_s;
    logic               pend_r;
    logic [4*NDIG-1:0]  pend_dig_r;
    logic [NDIG-1:0]    pend_dp_r;
    logic [NDIG-1:0]    pend_en_r;
    logic [4*NDIG-1:0]  act_dig_r;
    logic [NDIG-1:0]    act_dp_r;
    logic [NDIG-1:0]    act_en_r;
    logic [6:0]         dec_s;
    logic [NDIG-1:0]    an_sel_s;
    logic [NDIG-1:0]    an_nx_s;
    logic [6:0]         seg_nx_s;
    logic               dp_nx_s;

    // Slot timing strobes and the lit-time length for the current brightness.
    always_comb begin
        tick_s       = (cnt_r == CNT_LAST);
        frame_edge_s = tick_s && (idx_r == IDX_LAST);
        on_len_s     = (SLOT_SPAN * (32'(br_r) + 32'd1)) >> 4;
        on_done_s    = (32'(cnt_r) + 32'd1 - 32'(BLANK)) >= on_len_s;
    end

    // Prescaler and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
            idx_r <= '0;
        end else if (tick_s) begin
            cnt_r <= '0;
            idx_r <= (idx_r == IDX_LAST) ? '0 : idx_r + 1'b1;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    // Brightness is frozen for the whole slot so the PWM width cannot change mid-slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_r <= 4'd0;
        end else if (cnt_r == '0) begin
            br_r <= bright_i;
        end else begin
            br_r <= br_r;
        end
    end

    // Slot state sequencing; a tick always restarts in dead time.
    always_comb begin
        state_nx_s = state_r;
        if (tick_s) begin
            state_nx_s = S_BLANK;
        end else begin
            case (state_r)
                S_BLANK: state_nx_s = (cnt_r == BLANK_LAST) ? S_ON : S_BLANK;
                S_ON:    state_nx_s = on_done_s ? S_OFF : S_ON;
                S_OFF:   state_nx_s = S_OFF;
                default: state_nx_s = S_BLANK;
            endcase
        end
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_BLANK;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Double buffer: a load coinciding with a frame edge keeps pend set for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r     <= 1'b0;
            pend_dig_r <= '0;
            pend_dp_r  <= '0;
            pend_en_r  <= '0;
            act_dig_r  <= '0;
            act_dp_r   <= '0;
            act_en_r   <= '0;
        end else begin
            if (frame_edge_s && pend_r) begin
                act_dig_r <= pend_dig_r;
                act_dp_r  <= pend_dp_r;
                act_en_r  <= pend_en_r;
            end else begin
                act_dig_r <= act_dig_r;
                act_dp_r  <= act_dp_r;
                act_en_r  <= act_en_r;
            end
            if (load_i) begin
                pend_dig_r <= digits_i;
                pend_dp_r  <= dp_i;
                pend_en_r  <= enable_i;
                pend_r     <= 1'b1;
            end else if (frame_edge_s) begin
                pend_r     <= 1'b0;
            end else begin
                pend_r     <= pend_r;
            end
        end
    end

    seg7_hex_decode u_dec (
        .hex_i (act_dig_r[{idx_r, 2'b00} +: 4]),
        .seg_o (dec_s)
    );

    // Next output values with polarity applied before the output register.
    always_comb begin
        an_sel_s = {{(NDIG-1){1'b0}}, 1'b1} << idx_r;
        if ((state_r == S_ON) && act_en_r[idx_r]) begin
            an_nx_s  = AN_ACT_LOW ? ~an_sel_s : an_sel_s;
            seg_nx_s = seg_polarity(dec_s, SEG_ACT_LOW);
            dp_nx_s  = act_dp_r[idx_r] ^ SEG_ACT_LOW;
        end else begin
            an_nx_s  = AN_IDLE;
            seg_nx_s = SEG_IDLE;
            dp_nx_s  = DP_IDLE;
        end
    end

    // Registered pin drivers; reset darkens the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_o <= AN_IDLE;
            seg_o   <= SEG_IDLE;
            dp_o    <= DP_IDLE;
            frame_o <= 1'b0;
        end else begin
            anode_o <= an_nx_s;
            seg_o   <= seg_nx_s;
            dp_o    <= dp_nx_s;
            frame_o <= frame_edge_s;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: cycle scoreboard from a timing model,
// a vector table of display settings, and hand-written tearing/reset sequences.
module tb_seg7_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int DIV   = 20;
    localparam int BLANK = 4;
    localparam int FR    = DIV * NDIG;

    // Active-low segment patterns for 0..F.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits_i;
    logic [3:0]  dp_i;
    logic [3:0]  enable_i;
    logic [3:0]  bright_i;
    logic        load_i;
    logic [3:0]  anode_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic        frame_o;

    seg7_scan_ctrl #(
        .NDIG(NDIG), .DIV(DIV), .BLANK(BLANK), .AN_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .digits_i (digits_i),
        .dp_i     (dp_i),
        .enable_i (enable_i),
        .bright_i (bright_i),
        .load_i   (load_i),
        .anode_o  (anode_o),
        .seg_o    (seg_o),
        .dp_o     (dp_o),
        .frame_o  (frame_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fr;
    } obs_t;

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [3:0]  br;
        int          exp_on;
        logic [6:0]  exp_seg0;
        logic        exp_dp0;
    } vec_t;

    obs_t sbq[$];
    vec_t vecs[6];
    int   errors = 0;
    int   checks = 0;

    // Behavioural model: position inside the frame plus the visible/pending buffers.
    int          pos;
    logic [15:0] m_dig, p_dig;
    logic [3:0]  m_dp, m_en, p_dp, p_en, m_br;
    logic        m_pend;

    task automatic model_reset();
        pos = 0; m_dig = 16'h0; p_dig = 16'h0; m_dp = 4'h0; m_en = 4'h0;
        p_dp = 4'h0; p_en = 4'h0; m_br = 4'h0; m_pend = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic obs_t expect_at(input int p);
        int   sc, si, onl;
        obs_t e;
        sc   = p % DIV;
        si   = (p / DIV) % NDIG;
        onl  = ((DIV - BLANK) * (int'(m_br) + 1)) / 16;
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
        e.fr = ((p % FR) == (FR - 1));
        if (sc >= BLANK && (sc - BLANK) < onl && m_en[si]) begin
            e.an  = ~(4'b0001 << si);
            e.seg = SEG_LUT[m_dig[4*si +: 4]];
            e.dp  = ~m_dp[si];
        end
        return e;
    endfunction

    // One clock: push the expectation, advance the model, compare after the edge.
    task automatic step();
        obs_t e, a;
        sbq.push_back(expect_at(pos));
        if (pos % DIV == 0) m_br = bright_i;
        if ((pos % FR) == (FR - 1) && m_pend) begin
            m_dig = p_dig; m_dp = p_dp; m_en = p_en; m_pend = 1'b0;
        end
        if (load_i) begin
            p_dig = digits_i; p_dp = dp_i; p_en = enable_i; m_pend = 1'b1;
        end
        @(posedge clk);
        pos++;
        @(negedge clk);
        e = sbq.pop_front();
        a = {anode_o, seg_o, dp_o, frame_o};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL scoreboard pos=%0d anode=%h/%h seg=%h/%h dp=%b/%b frame=%b/%b (got/expected)",
                     pos - 1, a.an, e.an, a.seg, e.seg, a.dp, e.dp, a.fr, e.fr);
        end
    endtask

    task automatic run_capture(input int n, input logic [3:0] an_want,
                               output logic [6:0] seg_seen, output logic dp_seen, output int hits);
        hits = 0; seg_seen = 7'h7F; dp_seen = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            if (anode_o == an_want) begin
                hits++; seg_seen = seg_o; dp_seen = dp_o;
            end
        end
    endtask

    task automatic load_now(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
        digits_i = d; dp_i = dp; enable_i = en; load_i = 1'b1;
        step();
        load_i = 1'b0;
    endtask

    initial begin
        logic [6:0] seg_seen;
        logic       dp_seen;
        int         hits;

        vecs[0] = '{16'h1234, 4'b0000, 4'hF, 4'd15, 16, 7'h19, 1'b1};
        vecs[1] = '{16'h1234, 4'b0000, 4'hF, 4'd3,  4,  7'h19, 1'b1};
        vecs[2] = '{16'h5678, 4'b0001, 4'b0101, 4'd15, 16, 7'h00, 1'b0};
        vecs[3] = '{16'h9ABF, 4'b0000, 4'hE, 4'd15, 0,  7'h0E, 1'b1};
        vecs[4] = '{16'h0C0D, 4'b0000, 4'hF, 4'd0,  1,  7'h21, 1'b1};
        vecs[5] = '{16'h0000, 4'b0000, 4'hF, 4'd7,  8,  7'h40, 1'b1};

        rst_n = 1'b0; digits_i = 16'h0; dp_i = 4'h0; enable_i = 4'h0;
        bright_i = 4'd15; load_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_anode", 32'(anode_o), 32'h0F);
        chk("reset_seg",   32'(seg_o),   32'h7F);
        chk("reset_dp",    32'(dp_o),    32'h1);
        chk("reset_frame", 32'(frame_o), 32'h0);
        rst_n = 1'b1;
        model_reset();

        // Three dark frames with no load.
        run_capture(3 * FR, 4'hE, seg_seen, dp_seen, hits);
        chk("dark_before_load", 32'(hits), 32'd0);

        foreach (vecs[v]) begin
            bright_i = vecs[v].br;
            while ((pos % FR) == (FR - 1)) step();
            load_now(vecs[v].dig, vecs[v].dp, vecs[v].en);
            while ((pos % FR) != 0) step();
            run_capture(FR, 4'hE, seg_seen, dp_seen, hits);
            chk($sformatf("vec%0d_on_clks", v), 32'(hits), 32'(vecs[v].exp_on));
            if (vecs[v].exp_on > 0) begin
                chk($sformatf("vec%0d_seg0", v), 32'(seg_seen), 32'(vecs[v].exp_seg0));
                chk($sformatf("vec%0d_dp0", v),  32'(dp_seen),  32'(vecs[v].exp_dp0));
            end
        end

        // Tearing: load mid-frame at idx 1, old value must persist to the boundary.
        bright_i = 4'd15;
        load_now(16'h1234, 4'h0, 4'hF);
        while ((pos % FR) != 0) step();
        while ((pos % FR) != 25) step();
        load_now(16'h8888, 4'h0, 4'hF);
        run_capture(FR - 26, 4'hD, seg_seen, dp_seen, hits);
        chk("tear_old_slot1", 32'(seg_seen), 32'h30);
        run_capture(FR, 4'hB, seg_seen, dp_seen, hits);
        chk("tear_new_slot2", 32'(seg_seen), 32'h00);

        // Load on the boundary cycle itself lands one frame later.
        while ((pos % FR) != (FR - 1)) step();
        load_now(16'hFFFF, 4'h0, 4'hF);
        run_capture(FR, 4'hE, seg_seen, dp_seen, hits);
        chk("edge_load_held", 32'(seg_seen), 32'h00);
        run_capture(FR, 4'hE, seg_seen, dp_seen, hits);
        chk("edge_load_applied", 32'(seg_seen), 32'h0E);

        // Asynchronous reset in the middle of a lit slot.
        while ((pos % DIV) != 10) step();
        chk("pre_reset_lit", 32'(anode_o), 32'h0E);
        rst_n = 1'b0;
        #1;
        chk("midreset_anode", 32'(anode_o), 32'h0F);
        chk("midreset_seg",   32'(seg_o),   32'h7F);
        chk("midreset_dp",    32'(dp_o),    32'h1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_capture(2 * FR, 4'hE, seg_seen, dp_seen, hits);
        chk("dark_after_reset", 32'(hits), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
